// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer and a saturating stall counter.
module pipe_stage_buf #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_FULL  = 2'd1;
   localparam logic [1:0] ST_BOTH  = 2'd2;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Handshake: a transfer happens on a cycle where valid and ready are both high;
   // valid never waits for ready, and a held entry stays stable until it fires.
   logic [1:0]        r_state;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic [DATA_W-1:0] r_main_data;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic [DATA_W-1:0] r_skid_data;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic [1:0] w_state_nxt;
   logic       w_accept;
   logic       w_fire;
   logic       w_stall;
   logic       w_ld_main_in;
   logic       w_ld_main_skid;
   logic       w_ld_skid;

   // Without a skid slot, ready must look through to downstream to keep full throughput.
   assign in_ready  = (SKID != 0) ? (r_state != ST_BOTH)
                                  : ((r_state == ST_EMPTY) || out_ready);
   assign out_valid = (r_state != ST_EMPTY);
   assign out_ctrl  = out_valid ? r_main_ctrl : '0;
   assign out_data  = r_main_data;
   assign occupancy = (r_state == ST_BOTH) ? 2'd2 :
                      (r_state == ST_FULL) ? 2'd1 : 2'd0;
   assign stall_cnt = r_stall_cnt;
   assign dbg_state = r_state;

   assign w_accept = in_valid && in_ready;
   assign w_fire   = out_valid && out_ready;
   assign w_stall  = out_valid && !out_ready;

   always_comb begin
      w_state_nxt    = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt  = ST_FULL;
               w_ld_main_in = 1'b1;
            end
         end
         ST_FULL: begin
            if (w_accept && w_fire) begin
               w_ld_main_in = 1'b1;
            end else if (w_accept && (SKID != 0)) begin
               w_state_nxt = ST_BOTH;
               w_ld_skid   = 1'b1;
            end else if (w_fire) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_BOTH: begin
            if (w_fire) begin
               w_state_nxt    = ST_FULL;
               w_ld_main_skid = 1'b1;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      // Flush drops everything held plus this cycle's accept; data registers keep their value.
      if (flush) begin
         w_state_nxt    = ST_EMPTY;
         w_ld_main_in   = 1'b0;
         w_ld_main_skid = 1'b0;
         w_ld_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_EMPTY;
         r_main_ctrl <= '0;
         r_main_data <= '0;
         r_skid_ctrl <= '0;
         r_skid_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ld_main_in) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
         end else if (w_ld_main_skid) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
         end
         if (w_ld_skid) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a SKID=1/CNT_W=4 instance and a SKID=0 instance
// checked every cycle against a FIFO-queue model, plus hand-computed literal pins.
module tb_pipe_stage_buf;

   typedef struct packed {
      logic [7:0]  c;
      logic [31:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic reset_n;

   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [7:0]  a_in_ctrl, a_out_ctrl;
   logic [31:0] a_in_data, a_out_data;
   logic [1:0]  a_occ, a_dbg;
   logic [3:0]  a_stall;

   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0]  b_in_ctrl, b_out_ctrl;
   logic [31:0] b_in_data, b_out_data;
   logic [1:0]  b_occ, b_dbg;
   logic [15:0] b_stall;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   ent_t        mq_a[$], mq_b[$];
   logic [31:0] m_last_a, m_last_b;
   int unsigned m_cnt_a, m_cnt_b;
   logic [31:0] obs_a[$], obs_b[$];
   logic [31:0] exp_q[$];
   bit          m_fire, m_acc;
   ent_t        m_e;

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_a (
      .clk(clk), .reset_n(reset_n), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
      .occupancy(a_occ), .stall_cnt(a_stall), .dbg_state(a_dbg)
   );

   pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_b (
      .clk(clk), .reset_n(reset_n), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
      .occupancy(b_occ), .stall_cnt(b_stall), .dbg_state(b_dbg)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc();
      cyc();
      reset_n = 1'b1;
   endtask

   task automatic chk_obs(input string name, input bit use_b);
      logic [31:0] got[$];
      got = use_b ? obs_b : obs_a;
      chk({name, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk({name, "_order"}, got[i], exp_q[i]);
   endtask

   // Model: each instance is a FIFO of capacity 2 (skid) or 1 (no skid); checked, then stepped, mid-cycle.
   always @(negedge clk) begin
      if (!reset_n) begin
         mq_a.delete(); mq_b.delete();
         m_last_a = '0; m_last_b = '0;
         m_cnt_a = 0; m_cnt_b = 0;
      end else begin
         if (chk_on) begin
            chk("a_out_valid", a_out_valid, mq_a.size() != 0);
            chk("a_out_ctrl", a_out_ctrl, (mq_a.size() != 0) ? mq_a[0].c : 8'h00);
            chk("a_out_data", a_out_data, (mq_a.size() != 0) ? mq_a[0].d : m_last_a);
            chk("a_occupancy", a_occ, mq_a.size());
            chk("a_dbg_state", a_dbg, mq_a.size());
            chk("a_in_ready", a_in_ready, mq_a.size() < 2);
            chk("a_stall_cnt", a_stall, m_cnt_a);
            chk("b_out_valid", b_out_valid, mq_b.size() != 0);
            chk("b_out_ctrl", b_out_ctrl, (mq_b.size() != 0) ? mq_b[0].c : 8'h00);
            chk("b_out_data", b_out_data, (mq_b.size() != 0) ? mq_b[0].d : m_last_b);
            chk("b_occupancy", b_occ, mq_b.size());
            chk("b_in_ready", b_in_ready, (mq_b.size() == 0) || b_out_ready);
            chk("b_stall_cnt", b_stall, m_cnt_b);
         end
         if (a_out_valid && a_out_ready) obs_a.push_back(a_out_data);
         if (b_out_valid && b_out_ready) obs_b.push_back(b_out_data);

         m_fire = (mq_a.size() != 0) && a_out_ready;
         m_acc  = a_in_valid && (mq_a.size() < 2);
         if ((mq_a.size() != 0) && !a_out_ready && (m_cnt_a < 15)) m_cnt_a++;
         if (mq_a.size() != 0) m_last_a = mq_a[0].d;
         if (a_flush) mq_a.delete();
         else begin
            if (m_fire) void'(mq_a.pop_front());
            if (m_acc) begin
               m_e.c = a_in_ctrl; m_e.d = a_in_data;
               mq_a.push_back(m_e);
            end
         end

         m_fire = (mq_b.size() != 0) && b_out_ready;
         m_acc  = b_in_valid && ((mq_b.size() == 0) || b_out_ready);
         if ((mq_b.size() != 0) && !b_out_ready && (m_cnt_b < 65535)) m_cnt_b++;
         if (mq_b.size() != 0) m_last_b = mq_b[0].d;
         if (b_flush) mq_b.delete();
         else begin
            if (m_fire) void'(mq_b.pop_front());
            if (m_acc) begin
               m_e.c = b_in_ctrl; m_e.d = b_in_data;
               mq_b.push_back(m_e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_ctrl = '0; a_in_data = '0;
      b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_ctrl = '0; b_in_data = '0;
      cyc();
      cyc();
      reset_n = 1'b1;
      chk_on  = 1'b1;
      chk("reset_a_in_ready", a_in_ready, 1);
      chk("reset_a_out_valid", a_out_valid, 0);
      chk("reset_a_out_data", a_out_data, 0);
      chk("reset_a_stall", a_stall, 0);
      chk("reset_b_in_ready", b_in_ready, 1);

      // Streaming through the skid instance
      a_out_ready = 1; a_in_valid = 1; a_in_ctrl = 8'h01;
      for (int i = 1; i <= 8; i++) begin
         a_in_data = i;
         cyc();
         chk("stream_a_data", a_out_data, i);
         chk("stream_a_occ", a_occ, 1);
         chk("stream_a_ctrl", a_out_ctrl, 8'h01);
      end
      a_in_valid = 0;
      cyc();
      chk("stream_a_drained", a_out_valid, 0);
      chk("stream_a_stall", a_stall, 0);
      exp_q.delete();
      for (int i = 1; i <= 8; i++) exp_q.push_back(i);
      chk_obs("stream_a", 1'b0);

      // Skid fill and release
      do_reset();
      obs_a.delete();
      a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 8'h02; a_in_data = 32'hA;
      cyc();
      a_in_data = 32'hB;
      cyc();
      chk("skid_occ_both", a_occ, 2);
      chk("skid_in_ready_low", a_in_ready, 0);
      a_in_data = 32'hC;
      cyc();
      chk("skid_hold_ready", a_in_ready, 0);
      cyc();
      a_out_ready = 1;
      cyc();
      chk("skid_head_b", a_out_data, 32'hB);
      cyc();
      chk("skid_head_c", a_out_data, 32'hC);
      a_in_valid = 0;
      cyc();
      chk("skid_empty", a_out_valid, 0);
      chk("skid_stall_cnt", a_stall, 3);
      exp_q = '{32'hA, 32'hB, 32'hC};
      chk_obs("skid_fill", 1'b0);

      // Flush while holding two entries
      do_reset();
      obs_a.delete();
      a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 8'h3C; a_in_data = 32'hA;
      cyc();
      a_in_data = 32'hB;
      cyc();
      a_in_valid = 0; a_flush = 1; a_out_ready = 1;
      cyc();
      a_flush = 0;
      chk("flush_both_valid", a_out_valid, 0);
      chk("flush_both_ctrl", a_out_ctrl, 0);
      chk("flush_both_occ", a_occ, 0);
      chk("flush_both_data_held", a_out_data, 32'hA);
      repeat (3) cyc();
      exp_q = '{32'hA};
      chk_obs("flush_both", 1'b0);

      // Flush with simultaneous accept from EMPTY
      obs_a.delete();
      a_in_valid = 1; a_in_data = 32'h55; a_flush = 1;
      cyc();
      a_flush = 0; a_in_valid = 0;
      chk("flush_acc_valid", a_out_valid, 0);
      chk("flush_acc_occ", a_occ, 0);
      chk("flush_acc_data_held", a_out_data, 32'hA);
      repeat (2) cyc();
      exp_q.delete();
      chk_obs("flush_acc", 1'b0);

      // Stall counter saturation, then asynchronous reset mid-cycle
      a_out_ready = 0; a_in_valid = 1; a_in_data = 32'h77;
      cyc();
      a_in_valid = 0;
      repeat (20) cyc();
      chk("sat_stall_cnt", a_stall, 15);
      chk("sat_still_valid", a_out_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_valid", a_out_valid, 0);
      chk("async_rst_occ", a_occ, 0);
      chk("async_rst_stall", a_stall, 0);
      chk("async_rst_data", a_out_data, 0);
      chk("async_rst_in_ready", a_in_ready, 1);
      cyc();
      cyc();
      reset_n = 1'b1;
      a_out_ready = 1;

      // Streaming through the no-skid instance
      obs_b.delete();
      b_out_ready = 1; b_in_valid = 1; b_in_ctrl = 8'h81;
      for (int i = 1; i <= 8; i++) begin
         b_in_data = 32'h100 + i;
         cyc();
         chk("stream_b_data", b_out_data, 32'h100 + i);
         chk("stream_b_occ", b_occ, 1);
      end
      b_in_valid = 0;
      cyc();
      chk("stream_b_drained", b_out_valid, 0);

      // Combinational ready with out_ready toggling while FULL
      obs_b.delete();
      b_in_valid = 1; b_in_data = 32'hD1;
      cyc();
      b_in_data = 32'hD2; b_out_ready = 1;
      #1 chk("comb_ready_1", b_in_ready, 1);
      cyc();
      b_in_data = 32'hD3; b_out_ready = 0;
      #1 chk("comb_ready_0", b_in_ready, 0);
      cyc();
      b_out_ready = 1;
      #1 chk("comb_ready_1b", b_in_ready, 1);
      cyc();
      b_in_valid = 0;
      cyc();
      cyc();
      exp_q = '{32'hD1, 32'hD2, 32'hD3};
      chk_obs("comb_ready", 1'b1);
      chk("comb_b_stall", b_stall, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
